// File: rtl/ctrl_pkg.sv
// Shared control types: operating config, frame size, loader FSM states, channel tags.
package ctrl_pkg;

  typedef enum logic [1:0] {
    f16bits = 2'd0,
    f31bits = 2'd1
  } frame_size_t;

  typedef struct packed {
    frame_size_t frame_size;
  } OP_t;

  typedef enum logic [1:0] {
    WAIT_L = 2'd0,
    WAIT_R = 2'd1,
    WR_L   = 2'd2,
    WR_R   = 2'd3
  } ldr_state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         wclk,
  input  logic         rst_,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/i2s_tx_loader.sv
// Pairs tagged L/R samples and writes each stereo pair into the TxFIFO as two words.
// Optional statistics counters are built when I2S_TX_LOADER_STATS_EN is defined.
module i2s_tx_loader
  import ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             wclk,
  input  logic             rst_,
  input  logic             en,
  input  OP_t              op,
  input  logic             mono,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             s_chan,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [DW-1:0]    fifo_din,
  output logic             ord_err,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  ldr_state_t    state_reg, state_next;
  logic [DW-1:0] hold_l_reg, hold_l_next;
  logic [DW-1:0] hold_r_reg, hold_r_next;
  logic          ord_err_reg, ord_err_next;
  logic [DW-1:0] word;
  logic          is_f16;
  logic          accept;

  // Only the f16bits encoding truncates; every other encoding passes the full word.
  assign is_f16 = (op.frame_size == f16bits);
  assign word[15:0] = s_data[15:0];

  generate
    for (genvar gi = 16; gi < DW; gi++) begin : g_fmt
      assign word[gi] = is_f16 ? 1'b0 : s_data[gi];
    end
  endgenerate

  // Gated by rst_ so s_ready is low for the whole reset, whatever en does.
  assign s_ready = rst_ && en && ((state_reg == WAIT_L) || (state_reg == WAIT_R));
  assign accept  = s_valid && s_ready;

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      state_reg   <= WAIT_L;
      hold_l_reg  <= '0;
      hold_r_reg  <= '0;
      ord_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_l_reg  <= hold_l_next;
      hold_r_reg  <= hold_r_next;
      ord_err_reg <= ord_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hold_l_next  = hold_l_reg;
    hold_r_next  = hold_r_reg;
    ord_err_next = 1'b0;
    fifo_write   = 1'b0;
    fifo_din     = '0;
    case (state_reg)
      WAIT_L: begin
        if (accept) begin
          if (mono) begin
            hold_l_next = word;
            hold_r_next = word;
            state_next  = WR_L;
          end else if (s_chan == CH_L) begin
            hold_l_next = word;
            state_next  = WAIT_R;
          end else begin
            ord_err_next = 1'b1;
          end
        end
      end
      WAIT_R: begin
        if (!en) begin
          hold_l_next = '0;
          state_next  = WAIT_L;
        end else if (accept) begin
          if (s_chan == CH_R) begin
            hold_r_next = word;
            state_next  = WR_L;
          end else begin
            // A second L replaces the held one; the pair restarts from it.
            hold_l_next  = word;
            ord_err_next = 1'b1;
          end
        end
      end
      WR_L: begin
        fifo_write = !fifo_full;
        if (!fifo_full) begin
          fifo_din   = hold_l_reg;
          state_next = WR_R;
        end
      end
      WR_R: begin
        fifo_write = !fifo_full;
        if (!fifo_full) begin
          fifo_din   = hold_r_reg;
          state_next = WAIT_L;
        end
      end
      default: state_next = WAIT_L;
    endcase
  end

  assign ord_err = ord_err_reg;

`ifdef I2S_TX_LOADER_STATS_EN
  logic pair_inc;
  assign pair_inc = (state_reg == WR_R) && fifo_write;

  sat_counter #(.W(CNT_W)) u_pair_cnt (
    .wclk (wclk),
    .rst_ (rst_),
    .inc  (pair_inc),
    .cnt  (pair_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .wclk (wclk),
    .rst_ (rst_),
    .inc  (ord_err_reg),
    .cnt  (err_cnt)
  );
`else
  assign pair_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_i2s_tx_loader.sv
// Directed self-checking bench for i2s_tx_loader; honours I2S_TX_LOADER_STATS_EN for counter expectations.
module tb_i2s_tx_loader;
  import ctrl_pkg::*;

  localparam int CNT_W = 16;
`ifdef I2S_TX_LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             wclk = 1'b0;
  logic             rst_ = 1'b0;
  logic             en = 1'b0;
  OP_t              op;
  logic             mono = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [31:0]      s_data = '0;
  logic             s_chan = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_write;
  logic [31:0]      fifo_din;
  logic             ord_err;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pairs = 0;
  int exp_errs  = 0;

  logic [31:0] wq[$];
  logic [31:0] eq[$];

  i2s_tx_loader #(.DW(32), .CNT_W(CNT_W)) dut (
    .wclk       (wclk),
    .rst_       (rst_),
    .en         (en),
    .op         (op),
    .mono       (mono),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_chan     (s_chan),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din),
    .ord_err    (ord_err),
    .pair_cnt   (pair_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 wclk = ~wclk;

  // Inputs change just after posedge, so the falling edge sees settled write data.
  always @(negedge wclk) begin
    if (fifo_write === 1'b1) wq.push_back(fifo_din);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input logic ch, input logic [31:0] d, input string tag);
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    #1;
    chk({tag, "_rdy"}, 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    #1;
    $display("[TB] %s: sent chan=%0d data=%h", tag, ch, d);
  endtask

  task automatic expq(input logic [31:0] v);
    eq.push_back(v);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, 32'(wq.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++) chk(tag, wq[i], eq[i]);
    wq.delete();
    eq.delete();
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_pair"}, 32'(pair_cnt), STATS ? 32'(exp_pairs) : 32'd0);
    chk({tag, "_err"},  32'(err_cnt),  STATS ? 32'(exp_errs)  : 32'd0);
  endtask

  initial begin
    op.frame_size = f31bits;
    en = 1'b1;
    // Reset state, with en already high
    tick();
    tick();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_write", 32'(fifo_write), 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_orderr", 32'(ord_err), 32'd0);
    chk_cnts("rst");
    rst_ = 1'b1;
    #1;
    chk("post_rst_ready", 32'(s_ready), 32'd1);

    // f31 pair: L written one cycle after R accept, R the cycle after
    send(CH_L, 32'hA5A5_0001, "s1_L");
    send(CH_R, 32'h5A5A_0002, "s1_R");
    chk("s1_wr_l", 32'(fifo_write), 32'd1);
    chk("s1_din_l", fifo_din, 32'hA5A5_0001);
    chk("s1_ready_busy", 32'(s_ready), 32'd0);
    tick();
    chk("s1_wr_r", 32'(fifo_write), 32'd1);
    chk("s1_din_r", fifo_din, 32'h5A5A_0002);
    tick();
    exp_pairs++;
    chk("s1_idle_wr", 32'(fifo_write), 32'd0);
    chk("s1_idle_din", fifo_din, 32'd0);
    chk_cnts("s1");
    expq(32'hA5A5_0001); expq(32'h5A5A_0002);
    cmp_q("s1_q");

    // f16 truncation
    op.frame_size = f16bits;
    send(CH_L, 32'hDEAD_BEEF, "s2_L");
    send(CH_R, 32'h1234_5678, "s2_R");
    chk("s2_din_l", fifo_din, 32'h0000_BEEF);
    tick();
    chk("s2_din_r", fifo_din, 32'h0000_5678);
    tick();
    exp_pairs++;
    expq(32'h0000_BEEF); expq(32'h0000_5678);
    cmp_q("s2_q");

    // Unlisted frame_size encoding behaves as f31; FIFO full stalls 5 cycles
    op.frame_size = frame_size_t'(2'd3);
    send(CH_L, 32'hCAFE_0001, "s3_L");
    fifo_full = 1'b1;
    send(CH_R, 32'hCAFE_0002, "s3_R");
    for (int i = 0; i < 5; i++) begin
      chk("s3_stall_wr", 32'(fifo_write), 32'd0);
      chk("s3_stall_rdy", 32'(s_ready), 32'd0);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("s3_din_l", fifo_din, 32'hCAFE_0001);
    tick();
    chk("s3_din_r", fifo_din, 32'hCAFE_0002);
    tick();
    exp_pairs++;
    chk_cnts("s3");
    expq(32'hCAFE_0001); expq(32'hCAFE_0002);
    cmp_q("s3_q");

    // L1, L2, R: one order error, L2 replaces L1
    op.frame_size = f31bits;
    send(CH_L, 32'h0000_0100, "s4_L1");
    chk("s4_noerr", 32'(ord_err), 32'd0);
    send(CH_L, 32'h0000_0200, "s4_L2");
    chk("s4_orderr", 32'(ord_err), 32'd1);
    send(CH_R, 32'h0000_0300, "s4_R");
    chk("s4_orderr_clr", 32'(ord_err), 32'd0);
    chk("s4_din_l", fifo_din, 32'h0000_0200);
    tick();
    chk("s4_din_r", fifo_din, 32'h0000_0300);
    tick();
    exp_pairs++;
    exp_errs++;
    chk_cnts("s4");
    expq(32'h0000_0200); expq(32'h0000_0300);
    cmp_q("s4_q");

    // R first: dropped, one-cycle ord_err, stays in WAIT_L
    send(CH_R, 32'h0000_0444, "s5_R");
    chk("s5_orderr", 32'(ord_err), 32'd1);
    chk("s5_wr", 32'(fifo_write), 32'd0);
    chk("s5_rdy", 32'(s_ready), 32'd1);
    tick();
    exp_errs++;
    chk("s5_orderr_pulse", 32'(ord_err), 32'd0);
    chk_cnts("s5");

    // en low in WAIT_R discards the held L without an error
    send(CH_L, 32'h0000_0077, "s6_L");
    en = 1'b0;
    #1;
    chk("s6_rdy_off", 32'(s_ready), 32'd0);
    tick();
    chk("s6_noerr", 32'(ord_err), 32'd0);
    en = 1'b1;
    send(CH_R, 32'h0000_0088, "s6_R");
    chk("s6_orderr", 32'(ord_err), 32'd1);
    chk("s6_wr", 32'(fifo_write), 32'd0);
    tick();
    exp_errs++;
    cmp_q("s6_q");

    // Mono: each sample duplicated, channel tag ignored
    mono = 1'b1;
    send(CH_R, 32'h0000_0011, "s7_a");
    tick(); tick();
    send(CH_L, 32'h0000_0022, "s7_b");
    tick(); tick();
    send(CH_R, 32'h0000_0033, "s7_c");
    tick(); tick();
    mono = 1'b0;
    exp_pairs += 3;
    chk_cnts("s7");
    expq(32'h11); expq(32'h11); expq(32'h22); expq(32'h22); expq(32'h33); expq(32'h33);
    cmp_q("s7_q");

    // Reset in WR_R while full: pair aborted, orphan L left in FIFO
    send(CH_L, 32'hAAAA_0001, "s8_L");
    send(CH_R, 32'hBBBB_0002, "s8_R");
    tick();
    fifo_full = 1'b1;
    #1;
    chk("s8_full_wr", 32'(fifo_write), 32'd0);
    rst_ = 1'b0;
    #1;
    chk("s8_rst_rdy", 32'(s_ready), 32'd0);
    chk("s8_rst_wr", 32'(fifo_write), 32'd0);
    chk("s8_rst_din", fifo_din, 32'd0);
    chk("s8_rst_orderr", 32'(ord_err), 32'd0);
    exp_pairs = 0;
    exp_errs = 0;
    chk_cnts("s8_rst");
    fifo_full = 1'b0;
    tick();
    rst_ = 1'b1;
    #1;
    chk("s8_rel_rdy", 32'(s_ready), 32'd1);
    chk("s8_rel_wr", 32'(fifo_write), 32'd0);
    chk_cnts("s8_rel");
    expq(32'hAAAA_0001);
    cmp_q("s8_q");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
